// File: rtl/lane_game_pkg.sv
// Shared types and constants for the lane-crossing game engine.
//   game_state_e : 2-bit game state encoding (PLAY/HIT/WON/OVER)
//   DIR_*        : lane rotate directions
//   move_e       : single move chosen from simultaneous button edges
//   pick_move    : fixed priority up > down > right > left
package lane_game_pkg;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HIT  = 2'd1,
    ST_WON  = 2'd2,
    ST_OVER = 2'd3
  } game_state_e;

  // Rotate toward bit COLS-1 (left) or toward bit 0 (right).
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int unsigned SPEED_W = 4;
  localparam int unsigned LIVES_W = 4;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned LEVEL_W = 4;

  // Bit positions inside the packed {up, down, right, left} button vector.
  localparam int unsigned BTN_UP    = 3;
  localparam int unsigned BTN_DOWN  = 2;
  localparam int unsigned BTN_RIGHT = 1;
  localparam int unsigned BTN_LEFT  = 0;

  typedef enum logic [2:0] {
    MV_NONE  = 3'd0,
    MV_UP    = 3'd1,
    MV_DOWN  = 3'd2,
    MV_RIGHT = 3'd3,
    MV_LEFT  = 3'd4
  } move_e;

  // Reduce simultaneous falling edges to one move.
  function automatic move_e pick_move(input logic [3:0] fall);
    move_e mv;
    mv = MV_NONE;
    if (fall[BTN_UP])         mv = MV_UP;
    else if (fall[BTN_DOWN])  mv = MV_DOWN;
    else if (fall[BTN_RIGHT]) mv = MV_RIGHT;
    else if (fall[BTN_LEFT])  mv = MV_LEFT;
    return mv;
  endfunction

endpackage

// File: rtl/lane_game_engine_if.sv
// Button/status bundle between the game engine and its board/VGA side.
//   master : drives up/down/left/right (active-low), reads game status
//   slave  : the engine; reads buttons, drives lane_map/frog/lives/score/
//            state/pulses (and level when LANE_GAME_LEVEL_EN is defined)
interface lane_game_engine_if #(
  parameter int unsigned COLS  = 8,
  parameter int unsigned LANES = 8
);
  localparam int unsigned ROW_W = $clog2(LANES);

  logic                   up;
  logic                   down;
  logic                   left;
  logic                   right;
  logic [LANES*COLS-1:0]  lane_map;
  logic [ROW_W-1:0]       frog_row;
  logic [COLS-1:0]        frog_col;
  logic [3:0]             lives;
  logic [7:0]             score;
  logic [1:0]             state;
  logic                   hit_pulse;
  logic                   win_pulse;
`ifdef LANE_GAME_LEVEL_EN
  logic [3:0]             level;

  modport master (output up, down, left, right,
                  input  lane_map, frog_row, frog_col, lives, score, state,
                         hit_pulse, win_pulse, level);
  modport slave  (input  up, down, left, right,
                  output lane_map, frog_row, frog_col, lives, score, state,
                         hit_pulse, win_pulse, level);
`else
  modport master (output up, down, left, right,
                  input  lane_map, frog_row, frog_col, lives, score, state,
                         hit_pulse, win_pulse);
  modport slave  (input  up, down, left, right,
                  output lane_map, frog_row, frog_col, lives, score, state,
                         hit_pulse, win_pulse);
`endif
endinterface

// File: rtl/lane_shifter.sv
// One traffic lane: COLS-bit rotating bitmap plus a speed sub-counter.
//   clk, rst_n : clock, async active-low reset (lane <= INIT, counter <= 0)
//   tick_i     : traffic tick (already gated off while the game is over)
//   dir_i      : DIR_RIGHT rotates toward bit 0, DIR_LEFT toward bit COLS-1
//   speed_i    : ticks per rotation step, 0 behaves as 1
//   lane_o     : registered lane bitmap
module lane_shifter
  import lane_game_pkg::*;
#(
  parameter int unsigned      COLS = 8,
  parameter logic [COLS-1:0]  INIT = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic               dir_i,
  input  logic [SPEED_W-1:0] speed_i,
  output logic [COLS-1:0]    lane_o
);

  logic [COLS-1:0]    lane_q, lane_d;
  logic [SPEED_W-1:0] sub_q, sub_d;
  logic [SPEED_W-1:0] last_c;

  assign last_c = (speed_i == '0) ? '0 : speed_i - SPEED_W'(1);

  // Step the lane once every speed_i ticks.
  always_comb begin
    lane_d = lane_q;
    sub_d  = sub_q;
    if (tick_i) begin
      if (sub_q >= last_c) begin
        sub_d  = '0;
        lane_d = (dir_i == DIR_RIGHT) ? {lane_q[0], lane_q[COLS-1:1]}
                                      : {lane_q[COLS-2:0], lane_q[COLS-1]};
      end else begin
        sub_d = sub_q + SPEED_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= INIT;
      sub_q  <= '0;
    end else begin
      lane_q <= lane_d;
      sub_q  <= sub_d;
    end
  end

  assign lane_o = lane_q;

endmodule

// File: rtl/lane_game_engine.sv
// Lane-crossing game engine: traffic, frog movement, lives, score, game FSM.
//   clk, reset : clock, asynchronous active-low reset
//   gif.slave  : active-low buttons in; lane bitmap, frog row/one-hot column,
//                lives, score, state and hit/win pulses out (all registered)
// Optional feature macro LANE_GAME_LEVEL_EN: adds a saturating level counter
// (bumped per win) that shortens the tick period to max(TICK_DIV>>level, 1).
module lane_game_engine
  import lane_game_pkg::*;
#(
  parameter int unsigned            COLS       = 8,
  parameter int unsigned            LANES      = 8,
  parameter int unsigned            TICK_DIV   = 100_000_000,
  parameter logic [LANES*COLS-1:0]  LANE_INIT  = 64'h00EE_11CC_0099_F000,
  parameter logic [LANES-1:0]       LANE_DIR   = '0,
  parameter logic [LANES*4-1:0]     LANE_SPEED = {LANES{4'h1}},
  parameter int unsigned            LIVES      = 3,
  parameter int unsigned            HOLD_TICKS = 2
) (
  input  logic               clk,
  input  logic               reset,
  lane_game_engine_if.slave  gif
);

  localparam int unsigned ROW_W  = $clog2(LANES);
  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [ROW_W-1:0]  START_ROW = ROW_W'(LANES - 1);
  localparam logic [COLS-1:0]   START_COL = COLS'(1) << (COLS / 2);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  game_state_e           state_q, state_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d, tick_last_c;
  logic [3:0]            btn_prev_q;
  logic [ROW_W-1:0]      frog_row_q, frog_row_d;
  logic [COLS-1:0]       frog_col_q, frog_col_d;
  logic [LIVES_W-1:0]    lives_q, lives_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  hit_pulse_q, hit_pulse_d;
  logic                  win_pulse_q, win_pulse_d;
  logic                  tick_c, lane_tick_c, collide_c;
  logic [3:0]            btn_c, fall_c;
  logic [COLS-1:0]       row_bits_c;
  logic [LANES*COLS-1:0] lane_bits;

  // Tick period: fixed, or shortened by the current level.
`ifdef LANE_GAME_LEVEL_EN
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [31:0]        period_c;
  assign period_c    = 32'(TICK_DIV) >> level_q;
  assign tick_last_c = (period_c <= 32'd1) ? '0 : TICK_W'(period_c - 32'd1);
  assign gif.level   = level_q;
`else
  assign tick_last_c = TICK_W'(TICK_DIV - 1);
`endif

  // >= keeps the divider sane if the period shrinks below the running count.
  assign tick_c      = (tick_cnt_q >= tick_last_c);
  assign tick_cnt_d  = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
  assign lane_tick_c = tick_c && (state_q != ST_OVER);

  for (genvar r = 0; r < LANES; r++) begin : g_lane
    lane_shifter #(
      .COLS (COLS),
      .INIT (LANE_INIT[r*COLS +: COLS])
    ) u_lane (
      .clk     (clk),
      .rst_n   (reset),
      .tick_i  (lane_tick_c),
      .dir_i   (LANE_DIR[r]),
      .speed_i (LANE_SPEED[r*SPEED_W +: SPEED_W]),
      .lane_o  (lane_bits[r*COLS +: COLS])
    );
  end

  // Falling edges: button was released last cycle and is pressed now.
  assign btn_c  = {gif.up, gif.down, gif.right, gif.left};
  assign fall_c = btn_prev_q & ~btn_c;

  assign row_bits_c = lane_bits[32'(frog_row_q) * COLS +: COLS];
  assign collide_c  = |(row_bits_c & frog_col_q);

  // Game FSM; a move is taken only on a PLAY cycle that stays in PLAY.
  always_comb begin
    state_d     = state_q;
    frog_row_d  = frog_row_q;
    frog_col_d  = frog_col_q;
    lives_d     = lives_q;
    score_d     = score_q;
    hold_d      = hold_q;
    hit_pulse_d = 1'b0;
    win_pulse_d = 1'b0;
`ifdef LANE_GAME_LEVEL_EN
    level_d     = level_q;
`endif
    unique case (state_q)
      ST_PLAY: begin
        hold_d = '0;
        if (collide_c) begin
          state_d     = ST_HIT;
          lives_d     = lives_q - LIVES_W'(1);
          hit_pulse_d = 1'b1;
        end else if (frog_row_q == '0) begin
          state_d     = ST_WON;
          score_d     = score_q + SCORE_W'(1);
          win_pulse_d = 1'b1;
`ifdef LANE_GAME_LEVEL_EN
          if (level_q != '1) level_d = level_q + LEVEL_W'(1);
`endif
        end else begin
          unique case (pick_move(fall_c))
            MV_UP:    if (frog_row_q != '0)        frog_row_d = frog_row_q - ROW_W'(1);
            MV_DOWN:  if (frog_row_q != START_ROW) frog_row_d = frog_row_q + ROW_W'(1);
            MV_RIGHT: if (!frog_col_q[0])          frog_col_d = frog_col_q >> 1;
            MV_LEFT:  if (!frog_col_q[COLS-1])     frog_col_d = frog_col_q << 1;
            default:  ;
          endcase
        end
      end
      ST_HIT, ST_WON: begin
        if (tick_c) begin
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if (state_q == ST_HIT && lives_q == '0) begin
              state_d = ST_OVER;
            end else begin
              state_d    = ST_PLAY;
              frog_row_d = START_ROW;
              frog_col_d = START_COL;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      ST_OVER: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_PLAY;
      tick_cnt_q  <= '0;
      btn_prev_q  <= '1;
      frog_row_q  <= START_ROW;
      frog_col_q  <= START_COL;
      lives_q     <= LIVES_W'(LIVES);
      score_q     <= '0;
      hold_q      <= '0;
      hit_pulse_q <= 1'b0;
      win_pulse_q <= 1'b0;
`ifdef LANE_GAME_LEVEL_EN
      level_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      btn_prev_q  <= btn_c;
      frog_row_q  <= frog_row_d;
      frog_col_q  <= frog_col_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      hold_q      <= hold_d;
      hit_pulse_q <= hit_pulse_d;
      win_pulse_q <= win_pulse_d;
`ifdef LANE_GAME_LEVEL_EN
      level_q     <= level_d;
`endif
    end
  end

  assign gif.lane_map  = lane_bits;
  assign gif.frog_row  = frog_row_q;
  assign gif.frog_col  = frog_col_q;
  assign gif.lives     = lives_q;
  assign gif.score     = score_q;
  assign gif.state     = state_q;
  assign gif.hit_pulse = hit_pulse_q;
  assign gif.win_pulse = win_pulse_q;

endmodule

// File: tb/tb_lane_game_engine.sv
// Randomised bench for lane_game_engine against a cycle-level game model
// kept in plain arithmetic: lanes as byte array, frog as row/column index.
module tb_lane_game_engine;

  localparam int unsigned COLS       = 8;
  localparam int unsigned LANES      = 8;
  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned LIVES      = 3;
  localparam int unsigned HOLD_TICKS = 2;
  // Rows 7 (start) and 0 (goal) empty, sparse single cars elsewhere.
  localparam logic [63:0] INIT  = 64'h00_80_01_08_00_40_02_00;
  localparam logic [7:0]  DIR   = 8'b0110_0100;
  // Rows 7..0: speeds 1,2,1,3,0,2,1,1 (row 3 uses 0, meaning 1).
  localparam logic [31:0] SPEED = {4'd1, 4'd2, 4'd1, 4'd3, 4'd0, 4'd2, 4'd1, 4'd1};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lane_game_engine_if #(.COLS(COLS), .LANES(LANES)) gif ();

  lane_game_engine #(
    .COLS       (COLS),
    .LANES      (LANES),
    .TICK_DIV   (TICK_DIV),
    .LANE_INIT  (INIT),
    .LANE_DIR   (DIR),
    .LANE_SPEED (SPEED),
    .LIVES      (LIVES),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .gif   (gif)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state. States: 0 PLAY, 1 HIT, 2 WON, 3 OVER.
  int              m_tcnt, m_row, m_col, m_lives, m_score, m_st, m_hold, m_level;
  int              m_sub [LANES];
  logic [COLS-1:0] m_lane [LANES];
  bit              m_hp, m_wp;
  logic [3:0]      m_prev;   // {up, down, right, left}, 1 = released

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tcnt = 0; m_row = LANES - 1; m_col = COLS / 2;
    m_lives = LIVES; m_score = 0; m_st = 0; m_hold = 0; m_level = 0;
    m_hp = 0; m_wp = 0; m_prev = 4'hF;
    for (int r = 0; r < LANES; r++) begin
      m_sub[r]  = 0;
      m_lane[r] = INIT[r*COLS +: COLS];
    end
  endtask

  // Advance the model by one clock given the buttons seen at that edge.
  task automatic model_step(input logic [3:0] btn);
    bit         tick, coll;
    logic [3:0] fall;
    int         period, spd;
    period = TICK_DIV;
`ifdef LANE_GAME_LEVEL_EN
    period = TICK_DIV >> m_level;
    if (period < 1) period = 1;
`endif
    tick   = (m_tcnt >= period - 1);
    coll   = m_lane[m_row][m_col];
    fall   = m_prev & ~btn;
    m_prev = btn;
    m_tcnt = tick ? 0 : m_tcnt + 1;
    m_hp   = 0;
    m_wp   = 0;
    if (tick && m_st != 3) begin
      for (int r = 0; r < LANES; r++) begin
        spd = int'(SPEED[r*4 +: 4]);
        if (spd == 0) spd = 1;
        if (m_sub[r] + 1 >= spd) begin
          m_sub[r] = 0;
          if (DIR[r]) m_lane[r] = (m_lane[r] >> 1) | (m_lane[r] << (COLS - 1));
          else        m_lane[r] = (m_lane[r] << 1) | (m_lane[r] >> (COLS - 1));
        end else begin
          m_sub[r] = m_sub[r] + 1;
        end
      end
    end
    case (m_st)
      0: begin
        if (coll) begin
          m_st = 1; m_lives = m_lives - 1; m_hp = 1; m_hold = 0;
        end else if (m_row == 0) begin
          m_st = 2; m_score = (m_score + 1) % 256; m_wp = 1; m_hold = 0;
          if (m_level < 15) m_level = m_level + 1;
        end else if (fall[3]) begin
          if (m_row > 0) m_row = m_row - 1;
        end else if (fall[2]) begin
          if (m_row < LANES - 1) m_row = m_row + 1;
        end else if (fall[1]) begin
          if (m_col > 0) m_col = m_col - 1;
        end else if (fall[0]) begin
          if (m_col < COLS - 1) m_col = m_col + 1;
        end
      end
      1, 2: begin
        if (tick) begin
          m_hold = m_hold + 1;
          if (m_hold == HOLD_TICKS) begin
            m_hold = 0;
            if (m_st == 1 && m_lives == 0) m_st = 3;
            else begin
              m_st = 0; m_row = LANES - 1; m_col = COLS / 2;
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    logic [63:0] exp_map;
    logic [63:0] one;
    exp_map = '0;
    for (int r = 0; r < LANES; r++) exp_map[r*COLS +: COLS] = m_lane[r];
    one = 64'd1;
    check("lane_map",  64'(gif.lane_map),  exp_map);
    check("frog_row",  64'(gif.frog_row),  64'(m_row));
    check("frog_col",  64'(gif.frog_col),  one << m_col);
    check("lives",     64'(gif.lives),     64'(m_lives));
    check("score",     64'(gif.score),     64'(m_score));
    check("state",     64'(gif.state),     64'(m_st));
    check("hit_pulse", 64'(gif.hit_pulse), 64'(m_hp));
    check("win_pulse", 64'(gif.win_pulse), 64'(m_wp));
`ifdef LANE_GAME_LEVEL_EN
    check("level",     64'(gif.level),     64'(m_level));
`endif
  endtask

  // Called at a falling clock edge; returns at the next falling edge.
  task automatic cycle(input logic [3:0] btn);
    {gif.up, gif.down, gif.right, gif.left} = btn;
    model_step(btn);
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  // Asynchronous reset: outputs must be back at reset values right away.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [3:0] btn_cur;
  bit         did_hit_reset;
  int         pick;

  initial begin
    {gif.up, gif.down, gif.right, gif.left} = 4'hF;
    reset = 1'b1;
    model_reset();
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_frog_row", 64'(gif.frog_row), 64'd7);
    check("rst_frog_col", 64'(gif.frog_col), 64'h10);
    check("rst_lives",    64'(gif.lives),    64'd3);
    check("rst_score",    64'(gif.score),    64'd0);
    check("rst_state",    64'(gif.state),    64'd0);
    compare_all();
    reset = 1'b1;

    // Held button: one move only, then up+left together.
    repeat (50) cycle(4'b0111);
    repeat (3)  cycle(4'b1111);
    repeat (3)  cycle(4'b0110);
    repeat (3)  cycle(4'b1111);

    btn_cur       = 4'hF;
    did_hit_reset = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (m_st == 1 && !did_hit_reset && $urandom_range(0, 3) == 0) begin
        do_reset();
        did_hit_reset = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end
      pick = $urandom_range(0, 99);
      if (pick < 40) begin
        btn_cur = btn_cur;
      end else if (pick < 60) begin
        btn_cur = 4'hF;
      end else begin
        btn_cur = 4'hF;
        if ($urandom_range(0, 99) < 60) btn_cur[3] = 1'b0;
        if ($urandom_range(0, 99) < 15) btn_cur[2] = 1'b0;
        if ($urandom_range(0, 99) < 20) btn_cur[1] = 1'b0;
        if ($urandom_range(0, 99) < 20) btn_cur[0] = 1'b0;
      end
      cycle(btn_cur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
